pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 187 ++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Program counter and instruction-fetch sequencer. It issues one BRAM read
// per instruction and captures the word the BRAM returns one cycle later.
// The word is then presented to decode over a valid/ready handshake.
// A redirect reloads the PC and abandons any fetch still in flight.
//
// FSM: IDLE -> ISSUE -> WAIT -> HOLD -> (ISSUE | IDLE)
//
// Parameters
//   ADDR_W    PC / BRAM address width
//   DATA_W    instruction word width
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk              in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   en               in   run enable; 0 stops new fetches from being issued
//   redirect_en      in   load PC from redirect_target and flush the fetch
//   redirect_target  in   jump/branch target address
//   mem_addr         out  BRAM read address
//   mem_rd_en        out  BRAM read strobe, high for one cycle per fetch
//   mem_data         in   BRAM read data, valid the cycle after mem_rd_en
//   instr            out  fetched instruction
//   instr_pc         out  address that instr was fetched from
//   instr_valid      out  instr / instr_pc valid
//   instr_ready      in   decode accepts instr this cycle
//   pc               out  current PC (address of the next fetch)
//   fetch_count      out  (FETCH_CNT_EN only) saturating count of accepted
//                         instructions
//
// Optional feature macro: FETCH_CNT_EN
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic              mem_rd_en_q,   mem_rd_en_d;
    logic [DATA_W-1:0] instr_q,       instr_d;
    logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
    logic              instr_valid_q, instr_valid_d;

    // A held instruction only counts as taken when no redirect drops it.
    logic accept;
    assign accept = instr_valid_q && instr_ready && !redirect_en;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_addr_d    = mem_addr_q;
        mem_rd_en_d   = 1'b0;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (redirect_en) begin
            // The word the BRAM returns this cycle belongs to the old path.
            // Drop it without capturing it and without advancing the PC.
            pc_d          = redirect_target;
            mem_addr_d    = redirect_target;
            instr_valid_d = 1'b0;
            if (en) begin
                state_d     = ISSUE;
                mem_rd_en_d = 1'b1;
            end else begin
                state_d     = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d     = ISSUE;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = pc_q;
                    end
                end
                ISSUE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    // The PC still holds the fetched address here, so it
                    // is tagged onto the instruction before being advanced.
                    instr_d       = mem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(1);
                    state_d       = HOLD;
                end
                HOLD: begin
                    if (accept) begin
                        instr_valid_d = 1'b0;
                        if (en) begin
                            state_d     = ISSUE;
                            mem_rd_en_d = 1'b1;
                            mem_addr_d  = pc_q;
                        end else begin
                            state_d     = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            mem_addr_q    <= RESET_PC;
            mem_rd_en_q   <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_addr_q    <= mem_addr_d;
            mem_rd_en_q   <= mem_rd_en_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (accept && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= 16'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign pc          = pc_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. The main instance has RESET_PC = 0.
// A second instance has RESET_PC = 16'hFFFF and shares the same stimulus,
// so it covers the PC wrap-around case.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        redirect_en;
    logic [15:0] redirect_target;
    logic        instr_ready;

    logic [15:0] mem_addr,  mem_addr2;
    logic        mem_rd_en, mem_rd_en2;
    logic [15:0] mem_data  = 16'h0;
    logic [15:0] mem_data2 = 16'h0;
    logic [15:0] instr,     instr2;
    logic [15:0] instr_pc,  instr_pc2;
    logic        instr_valid, instr_valid2;
    logic [15:0] pc,        pc2;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_count, fetch_count2;
`endif

    logic [15:0] bram [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .redirect_en(redirect_en), .redirect_target(redirect_target),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en),
        .redirect_en(redirect_en), .redirect_target(redirect_target),
        .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_data(mem_data2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready), .pc(pc2)
`ifdef FETCH_CNT_EN
        , .fetch_count(fetch_count2)
`endif
    );

    // Synchronous-read BRAM models: data appears the cycle after the strobe.
    always @(posedge clk) if (mem_rd_en)  mem_data  <= bram[mem_addr];
    always @(posedge clk) if (mem_rd_en2) mem_data2 <= bram[mem_addr2];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " pc"},        32'(pc),          32'h0);
        check_eq({tag, " mem_addr"},  32'(mem_addr),    32'h0);
        check_eq({tag, " mem_rd_en"}, 32'(mem_rd_en),   32'h0);
        check_eq({tag, " instr"},     32'(instr),       32'h0);
        check_eq({tag, " instr_pc"},  32'(instr_pc),    32'h0);
        check_eq({tag, " valid"},     32'(instr_valid), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) bram[i] = 16'(i) ^ 16'h5A5A;
        bram[16'h0000] = 16'hA001;
        bram[16'h0001] = 16'hA002;
        bram[16'h0002] = 16'hA003;
        bram[16'h0040] = 16'hB040;
        bram[16'h0080] = 16'hB080;
        bram[16'hFFFF] = 16'h1234;

        reset_n = 1'b0; en = 1'b0; redirect_en = 1'b0;
        redirect_target = 16'h0; instr_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check_reset_vals("rst");
        check_eq("rst2 pc",       32'(pc2),       32'hFFFF);
        check_eq("rst2 mem_addr", 32'(mem_addr2), 32'hFFFF);

        // Sequential fetch with ready held high
        reset_n = 1'b1; en = 1'b1; instr_ready = 1'b1;
        tick();
        check_eq("t1 issue0 rd",   32'(mem_rd_en), 32'h1);
        check_eq("t1 issue0 addr", 32'(mem_addr),  32'h0);
        check_eq("t1 wrap issue addr", 32'(mem_addr2), 32'hFFFF);
        tick();
        check_eq("t1 wait rd",    32'(mem_rd_en),   32'h0);
        check_eq("t1 wait valid", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t1 i0 valid", 32'(instr_valid), 32'h1);
        check_eq("t1 i0 instr", 32'(instr),       32'hA001);
        check_eq("t1 i0 ipc",   32'(instr_pc),    32'h0);
        check_eq("t1 i0 pc",    32'(pc),          32'h1);
        check_eq("t1 wrap instr", 32'(instr2),    32'h1234);
        check_eq("t1 wrap ipc",   32'(instr_pc2), 32'hFFFF);
        check_eq("t1 wrap pc",    32'(pc2),       32'h0);
        tick();
        check_eq("t1 issue1 valid", 32'(instr_valid), 32'h0);
        check_eq("t1 issue1 rd",    32'(mem_rd_en),   32'h1);
        check_eq("t1 issue1 addr",  32'(mem_addr),    32'h1);
        check_eq("t1 wrap next addr", 32'(mem_addr2), 32'h0);
        check_eq("t1 wrap next rd",   32'(mem_rd_en2), 32'h1);
        repeat (2) tick();
        check_eq("t1 i1 valid", 32'(instr_valid), 32'h1);
        check_eq("t1 i1 instr", 32'(instr),       32'hA002);
        check_eq("t1 i1 ipc",   32'(instr_pc),    32'h1);
        check_eq("t1 wrap i1 instr", 32'(instr2), 32'hA001);
        tick();
        check_eq("t1 issue2 addr", 32'(mem_addr), 32'h2);
        repeat (2) tick();
        check_eq("t1 i2 instr", 32'(instr),    32'hA003);
        check_eq("t1 i2 ipc",   32'(instr_pc), 32'h2);
        check_eq("t1 i2 pc",    32'(pc),       32'h3);
        en = 1'b0;
        tick();
        check_eq("t1 idle valid", 32'(instr_valid), 32'h0);
        check_eq("t1 idle rd",    32'(mem_rd_en),   32'h0);
        check_eq("t1 idle pc",    32'(pc),          32'h3);
`ifdef FETCH_CNT_EN
        check_eq("t1 count",  32'(fetch_count),  32'd3);
        check_eq("t1 count2", 32'(fetch_count2), 32'd3);
`endif
        tick();
        check_eq("t1 stay idle rd", 32'(mem_rd_en), 32'h0);

        // Back-pressure: ready low for 5 cycles
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; en = 1'b1; instr_ready = 1'b0;
        repeat (3) tick();
        check_eq("t2 valid", 32'(instr_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2 hold instr", 32'(instr),       32'hA001);
            check_eq("t2 hold valid", 32'(instr_valid), 32'h1);
            check_eq("t2 hold rd",    32'(mem_rd_en),   32'h0);
            check_eq("t2 hold pc",    32'(pc),          32'h1);
        end
        instr_ready = 1'b1;
        tick();
        check_eq("t2 reissue rd",    32'(mem_rd_en),   32'h1);
        check_eq("t2 reissue addr",  32'(mem_addr),    32'h1);
        check_eq("t2 reissue valid", 32'(instr_valid), 32'h0);
        instr_ready = 1'b0;
        tick();

        // Redirect during WAIT
        redirect_en = 1'b1; redirect_target = 16'h0040;
        tick();
        check_eq("t3 redir valid", 32'(instr_valid), 32'h0);
        check_eq("t3 redir rd",    32'(mem_rd_en),   32'h1);
        check_eq("t3 redir addr",  32'(mem_addr),    32'h0040);
        check_eq("t3 redir pc",    32'(pc),          32'h0040);
        redirect_en = 1'b0;
        tick();
        check_eq("t3 wait valid", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t3 valid", 32'(instr_valid), 32'h1);
        check_eq("t3 instr", 32'(instr),       32'hB040);
        check_eq("t3 ipc",   32'(instr_pc),    32'h0040);
        check_eq("t3 pc",    32'(pc),          32'h0041);
`ifdef FETCH_CNT_EN
        check_eq("t3 count", 32'(fetch_count), 32'd1);
`endif

        // Redirect coincident with ready in HOLD
        redirect_en = 1'b1; redirect_target = 16'h0080; instr_ready = 1'b1;
        tick();
        check_eq("t4 valid", 32'(instr_valid), 32'h0);
        check_eq("t4 pc",    32'(pc),          32'h0080);
        check_eq("t4 addr",  32'(mem_addr),    32'h0080);
        check_eq("t4 rd",    32'(mem_rd_en),   32'h1);
`ifdef FETCH_CNT_EN
        check_eq("t4 count unchanged", 32'(fetch_count), 32'd1);
`endif
        redirect_en = 1'b0;
        repeat (2) tick();
        check_eq("t4 instr", 32'(instr),    32'hB080);
        check_eq("t4 ipc",   32'(instr_pc), 32'h0080);
        tick();
        check_eq("t4 next addr", 32'(mem_addr), 32'h0081);
`ifdef FETCH_CNT_EN
        check_eq("t4 count", 32'(fetch_count), 32'd2);
`endif
        tick();

        // Asynchronous reset during WAIT
        reset_n = 1'b0;
        #1;
        check_reset_vals("t5 async");
`ifdef FETCH_CNT_EN
        check_eq("t5 count", 32'(fetch_count), 32'd0);
`endif
        tick();
        reset_n = 1'b1;
        check_eq("t5 rel valid", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t5 first rd",   32'(mem_rd_en), 32'h1);
        check_eq("t5 first addr", 32'(mem_addr),  32'h0);
        tick();
        check_eq("t5 wait valid", 32'(instr_valid), 32'h0);
        tick();
        check_eq("t5 valid", 32'(instr_valid), 32'h1);
        check_eq("t5 instr", 32'(instr),       32'hA001);

        // en low at acceptance -> IDLE, no further issue
        en = 1'b0;
        tick();
        check_eq("t6 valid", 32'(instr_valid), 32'h0);
        check_eq("t6 rd",    32'(mem_rd_en),   32'h0);
        tick();
        check_eq("t6 stay rd", 32'(mem_rd_en), 32'h0);
        check_eq("t6 pc",      32'(pc),        32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
